// File: rtl/update_scheduler_if.sv
// Update-stream handshake between an update producer and the scheduler.
// The producer owns valid and payload; the scheduler owns ready.
interface update_scheduler_if #(
  parameter int PRED_W   = 5,
  parameter int WEIGHT_W = 32
);
  logic                upd_valid;
  logic                upd_ready;
  logic [PRED_W-1:0]   upd_src;
  logic [PRED_W-1:0]   upd_dst;
  logic [WEIGHT_W-1:0] upd_w;
  logic                upd_last;

  modport master (
    output upd_valid, upd_src, upd_dst, upd_w, upd_last,
    input  upd_ready
  );

  modport slave (
    input  upd_valid, upd_src, upd_dst, upd_w, upd_last,
    output upd_ready
  );
endinterface

// File: rtl/update_scheduler.sv
// Buffers edge updates, writes them into the adjacency matrix (optionally with a
// negated reverse edge) and runs the Bellman then cycle-detect engines after each batch.
module update_scheduler #(
  parameter int VERTS    = 32,
  parameter int WEIGHT_W = 32,
  parameter int QDEPTH   = 4,
  parameter int REV_MODE = 1,
  parameter int TIMEOUT  = 65535,
  localparam int PRED_W  = $clog2(VERTS)
) (
  input  logic                clk,
  input  logic                sched_reset_n,
  update_scheduler_if.slave   upd,
  output logic                adj_we,
  output logic [PRED_W-1:0]   adj_row,
  output logic [PRED_W-1:0]   adj_col,
  output logic [WEIGHT_W-1:0] adj_data,
  output logic                bf_start,
  output logic                cd_start,
  input  logic                bf_done,
  input  logic                cd_done,
  output logic [1:0]          eng_sel,
  output logic                busy,
  output logic                run_done,
  output logic                err_timeout,
  output logic [2:0]          state_dbg
);

  localparam int  ENT_W  = 2 * PRED_W + WEIGHT_W + 1;
  localparam int  AW     = $clog2(QDEPTH);
  localparam int  CW     = AW + 1;
  localparam int  CNT_W  = $clog2(TIMEOUT + 1) + 1;
  localparam bit  REV_EN = (REV_MODE != 32'd0);

  typedef enum logic [2:0] {
    S_IDLE     = 3'd0,
    S_WR_FWD   = 3'd1,
    S_WR_REV   = 3'd2,
    S_START_BF = 3'd3,
    S_RUN_BF   = 3'd4,
    S_START_CD = 3'd5,
    S_RUN_CD   = 3'd6,
    S_DONE     = 3'd7
  } state_t;

  state_t              state_r, state_nxt_s;
  logic [ENT_W-1:0]    fifo_mem_r [QDEPTH];
  logic [AW-1:0]       wr_ptr_r, rd_ptr_r;
  logic [CW-1:0]       count_r, count_nxt_s;
  logic                upd_ready_r;
  logic [ENT_W-1:0]    entry_r;
  logic [CNT_W-1:0]    tmo_cnt_r;
  logic                push_s, pop_s, empty_s, cnt_clr_s, cnt_inc_s, tmo_hit_s;
  logic                ent_last_s;
  logic [PRED_W-1:0]   ent_src_s, ent_dst_s;
  logic [WEIGHT_W-1:0] ent_w_s;

  assign upd.upd_ready = upd_ready_r;
  assign push_s        = upd.upd_valid && upd_ready_r;
  assign empty_s       = (count_r == {CW{1'b0}});
  assign {ent_last_s, ent_src_s, ent_dst_s, ent_w_s} = entry_r;

  // Next FIFO occupancy; simultaneous push and pop cancel out.
  always_comb begin
    count_nxt_s = count_r;
    case ({push_s, pop_s})
      2'b10:   count_nxt_s = count_r + CW'(32'd1);
      2'b01:   count_nxt_s = count_r - CW'(32'd1);
      default: count_nxt_s = count_r;
    endcase
  end

  // Update FIFO storage, pointers, occupancy and the registered ready flag.
  always_ff @(posedge clk or negedge sched_reset_n) begin
    if (!sched_reset_n) begin
      for (int i = 0; i < QDEPTH; i++) fifo_mem_r[i] <= {ENT_W{1'b0}};
      wr_ptr_r    <= {AW{1'b0}};
      rd_ptr_r    <= {AW{1'b0}};
      count_r     <= {CW{1'b0}};
      upd_ready_r <= 1'b0;
      entry_r     <= {ENT_W{1'b0}};
    end else begin
      if (push_s) begin
        fifo_mem_r[wr_ptr_r] <= {upd.upd_last, upd.upd_src, upd.upd_dst, upd.upd_w};
        wr_ptr_r             <= wr_ptr_r + AW'(32'd1);
      end
      if (pop_s) begin
        entry_r  <= fifo_mem_r[rd_ptr_r];
        rd_ptr_r <= rd_ptr_r + AW'(32'd1);
      end
      count_r     <= count_nxt_s;
      upd_ready_r <= (count_nxt_s != CW'(QDEPTH));
    end
  end

  // Sequencer next-state logic and counter/FIFO control strobes.
  always_comb begin
    state_nxt_s = state_r;
    pop_s       = 1'b0;
    cnt_clr_s   = 1'b0;
    cnt_inc_s   = 1'b0;
    tmo_hit_s   = 1'b0;
    case (state_r)
      S_IDLE: begin
        if (!empty_s) begin
          pop_s       = 1'b1;
          state_nxt_s = S_WR_FWD;
        end else begin
          state_nxt_s = S_IDLE;
        end
      end
      S_WR_FWD: begin
        if (REV_EN && (ent_src_s != ent_dst_s)) state_nxt_s = S_WR_REV;
        else if (ent_last_s)                    state_nxt_s = S_START_BF;
        else                                    state_nxt_s = S_IDLE;
      end
      S_WR_REV: begin
        if (ent_last_s) state_nxt_s = S_START_BF;
        else            state_nxt_s = S_IDLE;
      end
      S_START_BF: begin
        cnt_clr_s   = 1'b1;
        state_nxt_s = S_RUN_BF;
      end
      S_RUN_BF: begin
        if (bf_done) begin
          state_nxt_s = S_START_CD;
        end else if (tmo_cnt_r == CNT_W'(TIMEOUT - 1)) begin
          tmo_hit_s   = 1'b1;
          state_nxt_s = S_DONE;
        end else begin
          cnt_inc_s   = 1'b1;
        end
      end
      S_START_CD: begin
        cnt_clr_s   = 1'b1;
        state_nxt_s = S_RUN_CD;
      end
      S_RUN_CD: begin
        if (cd_done) begin
          state_nxt_s = S_DONE;
        end else if (tmo_cnt_r == CNT_W'(TIMEOUT - 1)) begin
          tmo_hit_s   = 1'b1;
          state_nxt_s = S_DONE;
        end else begin
          cnt_inc_s   = 1'b1;
        end
      end
      S_DONE:  state_nxt_s = S_IDLE;
      default: state_nxt_s = S_IDLE;
    endcase
  end

  // State register, engine watchdog counter and sticky timeout flag.
  always_ff @(posedge clk or negedge sched_reset_n) begin
    if (!sched_reset_n) begin
      state_r     <= S_IDLE;
      tmo_cnt_r   <= {CNT_W{1'b0}};
      err_timeout <= 1'b0;
    end else begin
      state_r <= state_nxt_s;
      if (cnt_clr_s)      tmo_cnt_r <= {CNT_W{1'b0}};
      else if (cnt_inc_s) tmo_cnt_r <= tmo_cnt_r + CNT_W'(32'd1);
      if (tmo_hit_s)      err_timeout <= 1'b1;
    end
  end

  // Registered decode of the current state; outputs trail the state by one cycle.
  always_ff @(posedge clk or negedge sched_reset_n) begin
    if (!sched_reset_n) begin
      adj_we    <= 1'b0;
      adj_row   <= {PRED_W{1'b0}};
      adj_col   <= {PRED_W{1'b0}};
      adj_data  <= {WEIGHT_W{1'b0}};
      bf_start  <= 1'b0;
      cd_start  <= 1'b0;
      eng_sel   <= 2'd0;
      busy      <= 1'b0;
      run_done  <= 1'b0;
      state_dbg <= 3'd0;
    end else begin
      adj_we <= (state_r == S_WR_FWD) || (state_r == S_WR_REV);
      if (state_r == S_WR_REV) begin
        adj_row  <= ent_dst_s;
        adj_col  <= ent_src_s;
        // Two's-complement negate; the most negative weight maps onto itself.
        adj_data <= (~ent_w_s) + WEIGHT_W'(32'd1);
      end else begin
        adj_row  <= ent_src_s;
        adj_col  <= ent_dst_s;
        adj_data <= ent_w_s;
      end
      bf_start <= (state_r == S_START_BF);
      cd_start <= (state_r == S_START_CD);
      case (state_r)
        S_START_BF, S_RUN_BF: eng_sel <= 2'd1;
        S_START_CD, S_RUN_CD: eng_sel <= 2'd2;
        default:              eng_sel <= 2'd0;
      endcase
      busy      <= !((state_r == S_IDLE) && empty_s);
      run_done  <= (state_r == S_DONE);
      state_dbg <= state_r;
    end
  end

endmodule

// File: tb/tb_update_scheduler.sv
// Directed self-checking bench for update_scheduler: write ordering, reverse edges,
// FIFO back-pressure, engine sequencing, timeout and asynchronous reset.
module tb_update_scheduler;
  localparam int PW = 5;
  localparam int WW = 32;

  logic          clk = 1'b0;
  logic          sched_reset_n;
  logic          adj_we, bf_start, cd_start, bf_done, cd_done;
  logic [PW-1:0] adj_row, adj_col;
  logic [WW-1:0] adj_data;
  logic [1:0]    eng_sel;
  logic          busy, run_done, err_timeout;
  logic [2:0]    state_dbg;

  int checks = 0;
  int errors = 0;
  int bf_cnt = 0;
  int cd_cnt = 0;
  int rd_cnt = 0;
  logic [2*PW+WW-1:0] wr_q[$];
  int base;

  update_scheduler_if #(.PRED_W(PW), .WEIGHT_W(WW)) uif ();

  update_scheduler #(.VERTS(32), .WEIGHT_W(WW), .QDEPTH(4), .REV_MODE(1), .TIMEOUT(16)) dut (
    .clk(clk), .sched_reset_n(sched_reset_n), .upd(uif.slave),
    .adj_we(adj_we), .adj_row(adj_row), .adj_col(adj_col), .adj_data(adj_data),
    .bf_start(bf_start), .cd_start(cd_start), .bf_done(bf_done), .cd_done(cd_done),
    .eng_sel(eng_sel), .busy(busy), .run_done(run_done), .err_timeout(err_timeout),
    .state_dbg(state_dbg)
  );

  always #5 clk = ~clk;

  always @(negedge clk) begin
    if (adj_we)   wr_q.push_back({adj_row, adj_col, adj_data});
    if (bf_start) bf_cnt++;
    if (cd_start) cd_cnt++;
    if (run_done) rd_cnt++;
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  function automatic int evt_val(input int sel);
    case (sel)
      0:       return bf_cnt;
      1:       return cd_cnt;
      2:       return rd_cnt;
      default: return wr_q.size();
    endcase
  endfunction

  // sel: 0 bf_start count, 1 cd_start count, 2 run_done count, 3 write count
  task automatic wait_evt(input int sel, input int target, input string tag);
    for (int i = 0; i < 100; i++) begin
      if (evt_val(sel) >= target) break;
      tick();
    end
    chk(tag, 64'(evt_val(sel) >= target), 64'd1);
  endtask

  task automatic push(input int s, input int d, input logic [WW-1:0] w, input logic l);
    uif.upd_valid = 1'b1;
    uif.upd_src   = PW'(s);
    uif.upd_dst   = PW'(d);
    uif.upd_w     = w;
    uif.upd_last  = l;
    tick();
    uif.upd_valid = 1'b0;
  endtask

  task automatic finish_engines(input string tag);
    bf_done = 1'b1;
    tick();
    bf_done = 1'b0;
    wait_evt(1, cd_cnt + 1, {tag, "_cd_start"});
    chk({tag, "_eng_cd"}, 64'(eng_sel), 64'd2);
    cd_done = 1'b1;
    tick();
    cd_done = 1'b0;
    wait_evt(2, rd_cnt + 1, {tag, "_run_done"});
  endtask

  initial begin
    sched_reset_n = 1'b0;
    uif.upd_valid = 1'b0;
    uif.upd_src   = '0;
    uif.upd_dst   = '0;
    uif.upd_w     = '0;
    uif.upd_last  = 1'b0;
    bf_done       = 1'b0;
    cd_done       = 1'b0;
    #12;
    chk("rst_ready", 64'(uif.upd_ready), 64'd0);
    chk("rst_busy", 64'(busy), 64'd0);
    chk("rst_adj_we", 64'(adj_we), 64'd0);
    chk("rst_eng_sel", 64'(eng_sel), 64'd0);
    chk("rst_state", 64'(state_dbg), 64'd0);
    #10 sched_reset_n = 1'b1;
    tick();
    chk("ready_after_rst", 64'(uif.upd_ready), 64'd1);

    // Forward write, negated reverse write, full engine sequence.
    wr_q.delete();
    push(3, 5, 32'd100, 1'b1);
    chk("lat_t1", 64'(adj_we), 64'd0);
    tick();
    chk("lat_t2", 64'(adj_we), 64'd0);
    tick();
    chk("fwd_we", 64'(adj_we), 64'd1);
    chk("fwd_data", 64'({adj_row, adj_col, adj_data}), 64'({5'd3, 5'd5, 32'd100}));
    chk("fwd_eng_sel", 64'(eng_sel), 64'd0);
    tick();
    chk("rev_data", 64'({adj_row, adj_col, adj_data}), 64'({5'd5, 5'd3, 32'hFFFF_FF9C}));
    tick();
    chk("we_low_after", 64'(adj_we), 64'd0);
    wait_evt(0, 1, "t1_bf_start");
    chk("t1_eng_bf", 64'(eng_sel), 64'd1);
    chk("t1_busy", 64'(busy), 64'd1);
    finish_engines("t1");
    chk("t1_eng_idle", 64'(eng_sel), 64'd0);
    chk("t1_err", 64'(err_timeout), 64'd0);
    tick();
    chk("t1_busy_end", 64'(busy), 64'd0);
    chk("t1_writes", 64'(wr_q.size()), 64'd2);

    // Most negative weight negates to itself; non-last update starts no run.
    wr_q.delete();
    base = bf_cnt;
    push(1, 2, 32'h8000_0000, 1'b0);
    wait_evt(3, 2, "t2_writes");
    chk("t2_rev_minneg", 64'(wr_q[1]), 64'({5'd2, 5'd1, 32'h8000_0000}));
    tick(); tick(); tick();
    chk("t2_no_bf", 64'(bf_cnt), 64'(base));

    // Back-pressure while the Bellman engine stalls.
    push(2, 9, 32'd11, 1'b1);
    wait_evt(0, base + 1, "t3_bf_start");
    wr_q.delete();
    push(1, 4, 32'd10, 1'b0);
    push(6, 8, -32'sd20, 1'b0);
    push(10, 3, 32'd30, 1'b0);
    chk("t3_ready_3", 64'(uif.upd_ready), 64'd1);
    push(12, 13, 32'd40, 1'b0);
    chk("t3_ready_full", 64'(uif.upd_ready), 64'd0);
    tick();
    chk("t3_no_writes_run", 64'(wr_q.size()), 64'd0);
    finish_engines("t3");
    chk("t3_ready_back", 64'(uif.upd_ready), 64'd1);
    wait_evt(3, 8, "t3_8writes");
    chk("t3_w0", 64'(wr_q[0]), 64'({5'd1, 5'd4, 32'd10}));
    chk("t3_w1", 64'(wr_q[1]), 64'({5'd4, 5'd1, -32'sd10}));
    chk("t3_w3", 64'(wr_q[3]), 64'({5'd8, 5'd6, 32'd20}));
    chk("t3_w6", 64'(wr_q[6]), 64'({5'd12, 5'd13, 32'd40}));
    chk("t3_w7", 64'(wr_q[7]), 64'({5'd13, 5'd12, -32'sd40}));

    // Self-loop: single forward write only.
    wr_q.delete();
    push(7, 7, 32'd40, 1'b1);
    wait_evt(0, bf_cnt + 1, "t4_bf_start");
    chk("t4_one_write", 64'(wr_q.size()), 64'd1);
    chk("t4_w0", 64'(wr_q[0]), 64'({5'd7, 5'd7, 32'd40}));
    finish_engines("t4");

    // Bellman engine never finishes: watchdog aborts the run.
    base = cd_cnt;
    push(0, 1, 32'd1, 1'b1);
    wait_evt(0, bf_cnt + 1, "t5_bf_start");
    for (int i = 0; i < 14; i++) tick();
    chk("t5_err_before", 64'(err_timeout), 64'd0);
    tick();
    chk("t5_err_set", 64'(err_timeout), 64'd1);
    wait_evt(2, rd_cnt + 1, "t5_run_done");
    for (int i = 0; i < 5; i++) tick();
    chk("t5_no_cd", 64'(cd_cnt), 64'(base));
    chk("t5_err_sticky", 64'(err_timeout), 64'd1);

    // Asynchronous reset while the cycle detector runs.
    push(4, 6, 32'd5, 1'b1);
    wait_evt(0, bf_cnt + 1, "t6_bf_start");
    bf_done = 1'b1;
    tick();
    bf_done = 1'b0;
    wait_evt(1, cd_cnt + 1, "t6_cd_start");
    tick();
    base = rd_cnt;
    #2 sched_reset_n = 1'b0;
    #1;
    chk("t6_eng_sel", 64'(eng_sel), 64'd0);
    chk("t6_busy", 64'(busy), 64'd0);
    chk("t6_state", 64'(state_dbg), 64'd0);
    chk("t6_err_clr", 64'(err_timeout), 64'd0);
    tick();
    sched_reset_n = 1'b1;
    cd_done = 1'b1;
    tick(); tick();
    cd_done = 1'b0;
    tick(); tick();
    chk("t6_no_run_done", 64'(rd_cnt), 64'(base));
    chk("t6_idle", 64'(state_dbg), 64'd0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule

// File: doc/update_scheduler.md
UPDATE_SCHEDULER -- requirements
Module: update_scheduler

Interface
REQ-001 Parameter VERTS, default 32: vertex count; PRED_W = clog2(VERTS) derived.
REQ-002 Parameter WEIGHT_W, default 32: edge weight width, two's complement.
REQ-003 Parameter QDEPTH, default 4: update FIFO depth, power of two, >= 2.
REQ-004 Parameter REV_MODE, default 1: 1 = also write reverse edge with negated weight; 0 = forward only.
REQ-005 Parameter TIMEOUT, default 65535: maximum engine run cycles before abort.
REQ-006 clk  in  1  sole clock; all state changes on rising edge.
REQ-007 sched_reset_n  in  1  asynchronous, active-low reset.
REQ-008 upd_valid  in  1  update offered.
REQ-009 upd_ready  out  1  FIFO can accept.
REQ-010 upd_src, upd_dst  in  PRED_W each  edge endpoints.
REQ-011 upd_w  in  WEIGHT_W  edge weight.
REQ-012 upd_last  in  1  final update of batch; triggers a run.
REQ-013 adj_we  out  1; adj_row, adj_col  out  PRED_W; adj_data  out  WEIGHT_W  adjacency-matrix write port.
REQ-014 bf_start, cd_start  out  1  one-cycle start pulses to Bellman and cycle-detect engines.
REQ-015 bf_done, cd_done  in  1  engine completion, sampled as level.
REQ-016 eng_sel  out  2  memory-mux owner: 0 scheduler, 1 Bellman, 2 cycle-detect.
REQ-017 busy  out  1; run_done  out  1 one-cycle pulse; err_timeout  out  1 sticky; state_dbg  out  3.

Function
REQ-018 Accept: handshake completes when upd_valid && upd_ready on a rising edge; {src,dst,w,last} pushed to FIFO.
REQ-019 upd_ready SHALL equal !full, independent of FSM state; pushes are accepted during engine runs.
REQ-020 Simultaneous push and pop SHALL leave occupancy unchanged; pointers wrap modulo QDEPTH.
REQ-021 FSM states: IDLE, WR_FWD, WR_REV, START_BF, RUN_BF, START_CD, RUN_CD, DONE.
REQ-022 IDLE: if FIFO non-empty, pop head into an entry register and go WR_FWD; else stay.
REQ-023 WR_FWD (1 cycle): adj_we=1, row=src, col=dst, data=w.
REQ-024 WR_FWD exit: to WR_REV if REV_MODE=1 and src!=dst; otherwise to START_BF if last=1, else IDLE.
REQ-025 WR_REV (1 cycle): adj_we=1, row=dst, col=src, data=-w truncated to WEIGHT_W (most negative value maps to itself); exit to START_BF if last, else IDLE.
REQ-026 adj_we SHALL be 0 in all other states; adj_row/adj_col/adj_data are don't-care when adj_we=0.
REQ-027 START_BF: bf_start=1 for exactly one cycle, eng_sel=1, timeout counter cleared; next RUN_BF.
REQ-028 RUN_BF: eng_sel=1; on bf_done=1 go START_CD; bf_done during START_BF is ignored.
REQ-029 START_CD: cd_start=1 one cycle, eng_sel=2, counter cleared; next RUN_CD; RUN_CD exits on cd_done=1 to DONE.
REQ-030 Timeout: counter increments each RUN_BF/RUN_CD cycle; reaching TIMEOUT sets err_timeout and goes DONE, skipping remaining engine.
REQ-031 DONE: run_done=1 for one cycle, eng_sel=0; next IDLE.
REQ-032 eng_sel=0 in IDLE, WR_FWD, WR_REV, DONE; busy=1 in every state except IDLE with empty FIFO.
REQ-033 Latency: update accepted at edge t into empty FIFO in IDLE -> adj_we high in the cycle after edge t+2.
REQ-034 state_dbg encodes states 0..7 in REQ-021 order.

Reset
REQ-035 Assertion of sched_reset_n=0 SHALL immediately force IDLE, empty FIFO, counter 0, err_timeout=0, all outputs 0 except upd_ready=0.
REQ-036 After deassertion, upd_ready=1 from the first rising edge; reset mid-run aborts with no start or done pulse.

Verification
REQ-037 REV_MODE=1, push (3,5,100,last=1) -> writes (3,5,100) then (5,3,-100), bf_start pulse, bf_done -> cd_start, cd_done -> run_done.
REQ-038 Push (7,7,40,last=1) -> single write (7,7,40), no reverse write.
REQ-039 Push 4 non-last updates while engines stall -> upd_ready falls after 4th; pop restores 1; 8 writes total in order after last.
REQ-040 TIMEOUT=16, bf_done held 0 -> err_timeout=1 at 16th RUN_BF cycle, no cd_start, run_done pulses, flag stays 1.
REQ-041 w=0x80000000 -> reverse write data 0x80000000.
REQ-042 Reset asserted in RUN_CD -> IDLE, eng_sel=0, busy=0 asynchronously; no run_done.
